// File: rtl/shift_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_pkg
//   Shared definitions for the shift sequencer slice.
//   - state_t   : sequencer FSM state encoding (IDLE, CLEAR, SHIFT, FIN)
//   - DW_DEF    : default data word width
//   - LW_DEF    : default length field width
//   - eff_len() : number of bits actually shifted, min(len, dw)
// ---------------------------------------------------------------------------
package shift_seq_ctrl_pkg;

    localparam int DW_DEF = 8;
    localparam int LW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // A requested length longer than the word cannot shift more bits than
    // the word holds, so it saturates at the word width.
    function automatic int eff_len(input int len, input int dw);
        return (len < dw) ? len : dw;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin arbiter with a last-grant pointer.
//   Ports:
//     clk    : clock, rising edge
//     rst    : synchronous active-high reset (tie winner -> requester 0)
//     req    : request vector, bit i from requester i
//     take   : the grant shown this cycle is being consumed; pointer moves
//     gnt    : one-hot grant (combinational, all zero when no request)
//     gnt_id : index of the granted requester (0 when no request)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // prio names the requester that wins a tie. After a consumed grant it
    // points at the other requester, so the one not served last wins next.
    logic prio;

    always_comb begin
        gnt_id = 1'b0;
        if (req == 2'b11) begin
            gnt_id = prio;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end

        gnt = 2'b00;
        if (req != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (take && (req != 2'b00)) begin
            prio <= ~gnt_id;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//   Serialises a data word from one of two requesters into a downstream
//   shift register (R / CE / SLI interface), MSB first.
//
//   Handshake: REQx is a level request. The controller samples REQx only in
//   IDLE; the winner's DATAx/LENx are captured on that same edge and ACKx
//   pulses for one cycle (the CLEAR cycle) to say "captured". A requester
//   may drop REQx after ACKx; if it keeps REQx high it is seen as a fresh
//   request the next time the controller is IDLE. Requests while BUSY are
//   not captured.
//
//   Sequence: IDLE -> CLEAR (SR_R, ACK) -> SHIFT x L (SR_CE, SR_SLI)
//             -> FIN (DONE, DONE_ID) -> IDLE, where L = min(LEN, DW).
//             L = 0 goes CLEAR -> FIN directly.
//
//   Ports:
//     CLK            : clock, rising edge
//     R              : synchronous active-high reset
//     REQ0/REQ1      : transfer requests
//     DATA0/DATA1    : word to serialise (DW bits)
//     LEN0/LEN1      : bits to shift (LW bits)
//     ACK0/ACK1      : one-cycle capture pulse
//     SR_R           : downstream shift register clear
//     SR_CE          : downstream shift enable
//     SR_SLI         : downstream serial data
//     BUSY           : high whenever not IDLE
//     DONE           : one-cycle completion pulse
//     DONE_ID        : requester of the completed transfer (valid with DONE)
//     dbg_state      : current FSM state, for observation
//   All outputs are registered: each output register is loaded with the
//   value that belongs to the state being entered.
// ---------------------------------------------------------------------------
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          CLK,
    input  logic          R,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic [DW-1:0] DATA0,
    input  logic [DW-1:0] DATA1,
    input  logic [LW-1:0] LEN0,
    input  logic [LW-1:0] LEN1,
    output logic          ACK0,
    output logic          ACK1,
    output logic          SR_R,
    output logic          SR_CE,
    output logic          SR_SLI,
    output logic          BUSY,
    output logic          DONE,
    output logic          DONE_ID,
    output state_t        dbg_state
);

    // Counter must represent values 0..DW (effective length up to DW).
    localparam int CW = $clog2(DW + 1);

    state_t        state, state_n;
    logic [DW-1:0] shreg, shreg_n;    // captured word, shifted left per bit
    logic [CW-1:0] len_q, len_n;      // captured effective length
    logic [CW-1:0] cnt, cnt_n;        // bits still to send after this one
    logic          gid, gid_n;        // captured requester index

    logic [1:0]    gnt;
    logic          gnt_id;
    logic          take;

    logic          ack0_n, ack1_n, srr_n, ce_n, sli_n, done_n, done_id_n;

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst    (R),
        .req    ({REQ1, REQ0}),
        .take   (take),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Next state, next datapath values and next (registered) outputs.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        len_n     = len_q;
        cnt_n     = cnt;
        gid_n     = gid;
        take      = 1'b0;
        ack0_n    = 1'b0;
        ack1_n    = 1'b0;
        srr_n     = 1'b0;
        ce_n      = 1'b0;
        sli_n     = 1'b0;
        done_n    = 1'b0;
        done_id_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (REQ0 || REQ1) begin
                    take    = 1'b1;
                    state_n = ST_CLEAR;
                    srr_n   = 1'b1;
                    ack0_n  = gnt[0];
                    ack1_n  = gnt[1];
                    gid_n   = gnt_id;
                    shreg_n = gnt_id ? DATA1 : DATA0;
                    len_n   = CW'(eff_len(int'(gnt_id ? LEN1 : LEN0), DW));
                end
            end

            ST_CLEAR: begin
                if (len_q == '0) begin
                    state_n   = ST_FIN;
                    done_n    = 1'b1;
                    done_id_n = gid;
                end else begin
                    // Entering SHIFT: first bit goes out now, len_q-1 remain.
                    state_n = ST_SHIFT;
                    ce_n    = 1'b1;
                    sli_n   = shreg[DW-1];
                    shreg_n = {shreg[DW-2:0], 1'b0};
                    cnt_n   = len_q - CW'(1);
                end
            end

            ST_SHIFT: begin
                if (cnt == '0) begin
                    state_n   = ST_FIN;
                    done_n    = 1'b1;
                    done_id_n = gid;
                end else begin
                    ce_n    = 1'b1;
                    sli_n   = shreg[DW-1];
                    shreg_n = {shreg[DW-2:0], 1'b0};
                    cnt_n   = cnt - CW'(1);
                end
            end

            ST_FIN: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            len_q   <= '0;
            cnt     <= '0;
            gid     <= 1'b0;
            ACK0    <= 1'b0;
            ACK1    <= 1'b0;
            SR_R    <= 1'b0;
            SR_CE   <= 1'b0;
            SR_SLI  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            DONE_ID <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            len_q   <= len_n;
            cnt     <= cnt_n;
            gid     <= gid_n;
            ACK0    <= ack0_n;
            ACK1    <= ack1_n;
            SR_R    <= srr_n;
            SR_CE   <= ce_n;
            SR_SLI  <= sli_n;
            BUSY    <= (state_n != ST_IDLE);
            DONE    <= done_n;
            DONE_ID <= done_id_n;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
//   Bench for shift_seq_ctrl. A transfer-level reference model predicts the
//   output trace: when the model is idle and a request is seen at an edge it
//   appends the whole expected trace of that transfer (CLEAR, L shift cycles,
//   FIN, one IDLE) to exp_q; every cycle the head of exp_q (or all-zero when
//   empty) is compared against the DUT. Table-driven transfers and a few
//   hand-written sequences add explicit checks on top.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;
    import shift_seq_ctrl_pkg::*;

    localparam int DW = 8;
    localparam int LW = 4;

    // ---------------- clock / reset / DUT ----------------
    logic          CLK = 1'b0;
    logic          R = 1'b1;
    logic          REQ0 = 1'b0;
    logic          REQ1 = 1'b0;
    logic [DW-1:0] DATA0 = '0;
    logic [DW-1:0] DATA1 = '0;
    logic [LW-1:0] LEN0 = '0;
    logic [LW-1:0] LEN1 = '0;
    logic          ACK0, ACK1, SR_R, SR_CE, SR_SLI, BUSY, DONE, DONE_ID;
    state_t        dbg_state;

    always #5 CLK = ~CLK;

    shift_seq_ctrl #(.DW(DW), .LW(LW)) dut (
        .CLK       (CLK),
        .R         (R),
        .REQ0      (REQ0),
        .REQ1      (REQ1),
        .DATA0     (DATA0),
        .DATA1     (DATA1),
        .LEN0      (LEN0),
        .LEN1      (LEN1),
        .ACK0      (ACK0),
        .ACK1      (ACK1),
        .SR_R      (SR_R),
        .SR_CE     (SR_CE),
        .SR_SLI    (SR_SLI),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DONE_ID   (DONE_ID),
        .dbg_state (dbg_state)
    );

    // Downstream 4-bit shift register driven by the controller.
    logic [3:0] ds_q;
    always_ff @(posedge CLK) begin
        if (SR_R)       ds_q <= 4'h0;
        else if (SR_CE) ds_q <= {ds_q[2:0], SR_SLI};
    end

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    logic       model_prio = 1'b0;   // requester winning a tie

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Output vector layout: {ACK0, ACK1, SR_R, SR_CE, SR_SLI, BUSY, DONE, DONE_ID}
    function automatic logic [7:0] vec(input logic a0, input logic a1, input logic srr,
                                       input logic ce, input logic sli, input logic busy,
                                       input logic done, input logic did);
        return {a0, a1, srr, ce, sli, busy, done, did};
    endfunction

    // Called just after an edge, with inputs still as they were at the edge.
    task automatic model_edge();
        logic          w;
        logic [DW-1:0] d;
        int            l;
        int            eff;
        if (R) begin
            exp_q.delete();
            model_prio = 1'b0;
        end else if (exp_q.size() == 0 && (REQ0 || REQ1)) begin
            w   = (REQ0 && REQ1) ? model_prio : REQ1;
            d   = w ? DATA1 : DATA0;
            l   = w ? int'(LEN1) : int'(LEN0);
            eff = (l > DW) ? DW : l;
            model_prio = ~w;
            exp_q.push_back(vec(~w, w, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
            for (int i = 0; i < eff; i++)
                exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b1, d[DW-1-i], 1'b1, 1'b0, 1'b0));
            exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w));
            exp_q.push_back(8'h00);
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        logic [7:0] e;
        logic [7:0] a;
        @(posedge CLK);
        #1;
        model_edge();
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 8'h00;
        a = {ACK0, ACK1, SR_R, SR_CE, SR_SLI, BUSY, DONE, DONE_ID};
        cyc++;
        check($sformatf("trace_cyc%0d", cyc), 32'(a), 32'(e));
    endtask

    task automatic do_reset(input int n);
        R = 1'b1;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        for (int i = 0; i < n; i++) tick();
        R = 1'b0;
    endtask

    // ---------------- table-driven single transfers ----------------
    typedef struct {
        logic       id;
        logic [7:0] data;
        logic [3:0] len;
        int         exp_ce;
        logic [7:0] exp_bits;   // shifted bits, MSB-aligned
        int         exp_done;   // cycles after the sampling edge
        logic [3:0] exp_ds;     // downstream register at DONE
        int         chg_off;    // cycle at which DATA/LEN are disturbed (0 = never)
    } vec_t;

    vec_t tbl[8];

    task automatic run_single(input vec_t v, input int idx);
        int         ack_id, ack_off, ce_cnt, done_off, done_id;
        logic [7:0] bits;
        logic [3:0] ds;
        ack_id = -1; ack_off = -1; ce_cnt = 0; done_off = -1; done_id = -1;
        bits = 8'h00; ds = 4'hx;

        DATA0 = 8'($urandom); LEN0 = 4'($urandom);
        DATA1 = 8'($urandom); LEN1 = 4'($urandom);
        if (v.id) begin REQ1 = 1'b1; DATA1 = v.data; LEN1 = v.len; end
        else      begin REQ0 = 1'b1; DATA0 = v.data; LEN0 = v.len; end
        tick();
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        for (int off = 1; off <= 24; off++) begin
            if (off > 1) tick();
            if (ACK0 && ACK1)  begin ack_id = 2; ack_off = off; end
            else if (ACK0)     begin ack_id = 0; ack_off = off; end
            else if (ACK1)     begin ack_id = 1; ack_off = off; end
            if (SR_CE) begin
                if (ce_cnt < 8) bits[7-ce_cnt] = SR_SLI;
                ce_cnt++;
            end
            if (off == v.chg_off) begin
                DATA0 = ~DATA0; DATA1 = ~DATA1;
                LEN0  = 4'd2;   LEN1  = 4'd2;
            end
            if (DONE) begin
                done_off = off;
                done_id  = int'(DONE_ID);
                ds       = ds_q;
                break;
            end
        end
        tick();
        check($sformatf("t%0d_ack_id", idx),   32'(ack_id),   32'(v.id));
        check($sformatf("t%0d_ack_off", idx),  32'(ack_off),  32'(1));
        check($sformatf("t%0d_ce_cnt", idx),   32'(ce_cnt),   32'(v.exp_ce));
        check($sformatf("t%0d_bits", idx),     32'(bits),     32'(v.exp_bits));
        check($sformatf("t%0d_done_off", idx), 32'(done_off), 32'(v.exp_done));
        check($sformatf("t%0d_done_id", idx),  32'(done_id),  32'(v.id));
        check($sformatf("t%0d_ds_q", idx),     32'(ds),       32'(v.exp_ds));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int         n_ack, n_done, ce1, ones1;
        logic       cur;
        logic [3:0] order;

        tbl[0] = '{1'b0, 8'hA5, 4'd8,  8, 8'hA5, 10, 4'h5, 0};
        tbl[1] = '{1'b1, 8'hF0, 4'd4,  4, 8'hF0,  6, 4'hF, 0};
        tbl[2] = '{1'b0, 8'h77, 4'd0,  0, 8'h00,  2, 4'h0, 0};
        tbl[3] = '{1'b0, 8'h3C, 4'd12, 8, 8'h3C, 10, 4'hC, 0};
        tbl[4] = '{1'b1, 8'h81, 4'd1,  1, 8'h80,  3, 4'h1, 0};
        tbl[5] = '{1'b0, 8'h5C, 4'd8,  8, 8'h5C, 10, 4'hC, 0};
        tbl[6] = '{1'b0, 8'hA5, 4'd8,  8, 8'hA5, 10, 4'h5, 4};
        tbl[7] = '{1'b1, 8'hC3, 4'd15, 8, 8'hC3, 10, 4'h3, 0};

        // Reset state.
        do_reset(2);
        check("reset_outputs",
              32'({ACK0, ACK1, SR_R, SR_CE, SR_SLI, BUSY, DONE, DONE_ID}), 32'(0));
        tick();

        for (int i = 0; i < 8; i++) run_single(tbl[i], i);

        // Contention: both requests held; grants must alternate 0,1,0,1.
        do_reset(1);
        DATA0 = 8'hA5; LEN0 = 4'd2;
        DATA1 = 8'hF0; LEN1 = 4'd4;
        REQ0 = 1'b1; REQ1 = 1'b1;
        n_ack = 0; n_done = 0; ce1 = 0; ones1 = 0; cur = 1'b0; order = 4'h0;
        for (int i = 0; i < 80 && n_done < 4; i++) begin
            tick();
            if (ACK0 || ACK1) begin
                if (n_ack < 4) order[3-n_ack] = ACK1;
                n_ack++;
                cur = ACK1;
            end
            if (SR_CE && cur) begin
                ce1++;
                if (SR_SLI) ones1++;
            end
            if (DONE) n_done++;
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        check("cont_order", 32'(order), 32'(4'b0101));
        check("cont_dones", 32'(n_done), 32'(4));
        check("cont_r1_ce", 32'(ce1), 32'(8));
        check("cont_r1_ones", 32'(ones1), 32'(8));
        for (int i = 0; i < 4; i++) tick();

        // Reset abort during the 4th SHIFT cycle, then REQ0 wins a tie.
        DATA0 = 8'hFF; LEN0 = 4'd8;
        REQ0 = 1'b1;
        tick();                          // sampling edge; now CLEAR
        REQ0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();   // SHIFT cycles 1..4
        check("abort_in_shift", 32'({SR_CE, BUSY}), 32'(2'b11));
        R = 1'b1;
        tick();
        R = 1'b0;
        check("abort_outputs",
              32'({ACK0, ACK1, SR_R, SR_CE, SR_SLI, BUSY, DONE, DONE_ID}), 32'(0));
        LEN0 = 4'd2; LEN1 = 4'd2;
        REQ0 = 1'b1; REQ1 = 1'b1;
        tick();
        REQ0 = 1'b0; REQ1 = 1'b0;
        check("abort_first_grant", 32'({ACK0, ACK1}), 32'(2'b10));
        for (int i = 0; i < 8; i++) tick();

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 500; i++) begin
            R     = ($urandom_range(0, 79) == 0);
            REQ0  = ($urandom_range(0, 2) == 0);
            REQ1  = ($urandom_range(0, 2) == 0);
            DATA0 = 8'($urandom);
            DATA1 = 8'($urandom);
            LEN0  = 4'($urandom_range(0, 15));
            LEN1  = 4'($urandom_range(0, 15));
            tick();
        end
        R = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("drain_idle", 32'({BUSY, 32'(exp_q.size())} != 0), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
